voice_allocator: RTL and testbench

- Polyphonic voice scheduler between the UART receiver and the tone/light datapath.
- Accepts key messages from URx and assigns each note-on to one of C_VOICES voice channels.
- Holds each voice for C_MUSIC ms; releases it on note-off or timeout.
- Arbitrates the finite voice pool, stealing the voice closest to expiry when all voices are busy.

---
 rtl/voice_allocator.sv | 197 +++++++++++++++++++
 tb/tb_voice_allocator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps UART key messages onto C_VOICES timed voice channels.
// Latency: outputs update 2 cycles after the accepted UART_valid rising edge (IDLE->DECODE->APPLY).
// Backpressure: none; messages accepted outside IDLE, with errors or code 0 are dropped and counted.
// Optional build macro VOICE_STEAL_EN: when defined, a note-on with no free voice steals the voice
// closest to expiry; when undefined, that note-on is dropped and counted instead.
module voice_allocator #(
  parameter int C_CLK_FRQ = 100_000_000,
  parameter int C_MUSIC   = 5,
  parameter int C_VOICES  = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  UART_valid,
  input  logic                  UART_err,
  input  logic [7:0]            UART_msg,
  output logic [C_VOICES-1:0]   voice_en,
  output logic [7*C_VOICES-1:0] voice_note,
  output logic                  steal,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned C_T = C_CLK_FRQ / 1000 * C_MUSIC;
  localparam int TW = $clog2(C_T + 1);
  localparam int IW = $clog2(C_VOICES);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_APPLY} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_valid_q;
  logic [7:0]          r_msg;
  logic [C_VOICES-1:0] r_voice_en;
  logic [6:0]          r_note  [C_VOICES];
  logic [TW-1:0]       r_timer [C_VOICES];
  logic                r_steal;
  logic [7:0]          r_drop_cnt;
  logic                r_match_vld, r_free_vld;
  logic [IW-1:0]       r_match_idx, r_free_idx;

  logic                w_accept, w_good, w_drop_acc, w_full_drop, w_steal_nxt;
  logic                w_match_vld, w_free_vld;
  logic [IW-1:0]       w_match_idx, w_free_idx;
  logic [C_VOICES-1:0] w_wr, w_clr;
  logic [8:0]          w_drop_sum;
`ifdef VOICE_STEAL_EN
  logic [IW-1:0]       r_victim_idx, w_victim_idx;
  logic [TW-1:0]       w_victim_tmr;
`endif

  // One accept per rising edge of UART_valid; good accepts need IDLE, no error, non-zero code.
  assign w_accept   = UART_valid & ~r_valid_q;
  assign w_good     = w_accept & ~UART_err & (UART_msg[6:0] != 7'd0) & (r_state == S_IDLE);
  assign w_drop_acc = w_accept & ~w_good;
  assign w_drop_sum = {1'b0, r_drop_cnt} + {8'd0, w_drop_acc} + {8'd0, w_full_drop};

  // FSM state register, edge detector and latched message.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= S_IDLE;
      r_valid_q <= 1'b0;
      r_msg     <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid_q <= UART_valid;
      if (w_good) r_msg <= UART_msg;
    end
  end

  // Next-state: a good accept walks IDLE -> DECODE -> APPLY -> IDLE.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   w_state_nxt = w_good ? S_DECODE : S_IDLE;
      S_DECODE: w_state_nxt = S_APPLY;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Decode on pre-expiry state; scanning downward lets the lowest index win every tie.
  always_comb begin
    w_match_vld = 1'b0;
    w_match_idx = '0;
    w_free_vld  = 1'b0;
    w_free_idx  = '0;
`ifdef VOICE_STEAL_EN
    w_victim_idx = '0;
    w_victim_tmr = '1;
`endif
    for (int i = C_VOICES - 1; i >= 0; i--) begin
      if (r_voice_en[i] && (r_note[i] == r_msg[6:0])) begin
        w_match_vld = 1'b1;
        w_match_idx = IW'(i);
      end
      if (!r_voice_en[i]) begin
        w_free_vld = 1'b1;
        w_free_idx = IW'(i);
      end
`ifdef VOICE_STEAL_EN
      if (r_voice_en[i] && (r_timer[i] <= w_victim_tmr)) begin
        w_victim_tmr = r_timer[i];
        w_victim_idx = IW'(i);
      end
`endif
    end
  end

  // Hold decode results for the APPLY cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_match_vld <= 1'b0;
      r_match_idx <= '0;
      r_free_vld  <= 1'b0;
      r_free_idx  <= '0;
`ifdef VOICE_STEAL_EN
      r_victim_idx <= '0;
`endif
    end else if (r_state == S_DECODE) begin
      r_match_vld <= w_match_vld;
      r_match_idx <= w_match_idx;
      r_free_vld  <= w_free_vld;
      r_free_idx  <= w_free_idx;
`ifdef VOICE_STEAL_EN
      r_victim_idx <= w_victim_idx;
`endif
    end
  end

  // APPLY action: retrigger match, fill free voice, else steal or drop; note-off clears match.
  always_comb begin
    w_wr        = '0;
    w_clr       = '0;
    w_steal_nxt = 1'b0;
    w_full_drop = 1'b0;
    if (r_state == S_APPLY) begin
      if (r_msg[7]) begin
        if (r_match_vld) w_clr[r_match_idx] = 1'b1;
      end else if (r_match_vld) begin
        w_wr[r_match_idx] = 1'b1;
      end else if (r_free_vld) begin
        w_wr[r_free_idx] = 1'b1;
      end else begin
`ifdef VOICE_STEAL_EN
        w_wr[r_victim_idx] = 1'b1;
        w_steal_nxt        = 1'b1;
`else
        w_full_drop = 1'b1;
`endif
      end
    end
  end

  // Per-voice state: an APPLY write beats a same-cycle expiry; active timers count down to 0.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_voice_en <= '0;
      for (int i = 0; i < C_VOICES; i++) begin
        r_note[i]  <= 7'd0;
        r_timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < C_VOICES; i++) begin
        if (w_wr[i]) begin
          r_voice_en[i] <= 1'b1;
          r_note[i]     <= r_msg[6:0];
          r_timer[i]    <= TW'(C_T);
        end else if (w_clr[i]) begin
          r_voice_en[i] <= 1'b0;
          r_timer[i]    <= '0;
        end else if (r_voice_en[i]) begin
          r_timer[i] <= r_timer[i] - 1'b1;
          if (r_timer[i] == TW'(1)) r_voice_en[i] <= 1'b0;
        end
      end
    end
  end

  // Steal pulse and saturating drop counter.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_steal    <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_steal    <= w_steal_nxt;
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  // Pack per-voice notes onto the flat output bus.
  always_comb begin
    voice_note = '0;
    for (int i = 0; i < C_VOICES; i++) voice_note[7*i +: 7] = r_note[i];
  end

  assign voice_en = r_voice_en;
  assign steal    = r_steal;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with a scaled clock (T = 4000 cycles) and 4 voices.
// Latency: each send returns just after the edge where the message's effect is visible.
// Backpressure: n/a; expectations for the no-free-voice case follow the VOICE_STEAL_EN build.
module tb_voice_allocator;

  localparam int T = 4000;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        UART_valid = 1'b0;
  logic        UART_err = 1'b0;
  logic [7:0]  UART_msg = 8'd0;
  logic [3:0]  voice_en;
  logic [27:0] voice_note;
  logic        steal;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad = 0;

  voice_allocator #(.C_CLK_FRQ(4_000_000), .C_MUSIC(1), .C_VOICES(4)) dut (
    .clk(clk), .rstb(rstb), .UART_valid(UART_valid), .UART_err(UART_err),
    .UART_msg(UART_msg), .voice_en(voice_en), .voice_note(voice_note),
    .steal(steal), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle valid pulse; returns after the APPLY edge.
  task automatic send(input logic [7:0] msg, input logic err);
    UART_msg = msg; UART_err = err; UART_valid = 1'b1;
    tick();
    UART_valid = 1'b0; UART_err = 1'b0;
    tick();
    tick();
  endtask

  task automatic apply_reset();
    UART_valid = 1'b0; UART_err = 1'b0;
    #2 rstb = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstb = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    UART_valid = 1'b0;
    rstb = 1'b0;
    #3;
    total++; if (voice_en !== 4'h0) begin bad++; $display("FAIL reset_en: got %h want 0", voice_en); end
    total++; if (voice_note !== 28'h0) begin bad++; $display("FAIL reset_note: got %h want 0", voice_note); end
    total++; if (steal !== 1'b0) begin bad++; $display("FAIL reset_steal: got %b want 0", steal); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    repeat (2) @(posedge clk);
    #2 rstb = 1'b1;
    tick();
  endtask

  task automatic test_single_note();
    UART_msg = 8'h7A; UART_err = 1'b0; UART_valid = 1'b1;
    repeat (3) tick();
    total++; if (voice_en !== 4'b0001) begin bad++; $display("FAIL single_en: got %b want 0001", voice_en); end
    total++; if (voice_note[6:0] !== 7'h7A) begin bad++; $display("FAIL single_note: got %h want 7a", voice_note[6:0]); end
    UART_valid = 1'b0;
    repeat (T - 1) tick();
    total++; if (voice_en !== 4'b0001) begin bad++; $display("FAIL single_hold: got %b want 0001", voice_en); end
    tick();
    total++; if (voice_en !== 4'b0000) begin bad++; $display("FAIL single_expire: got %b want 0000", voice_en); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL single_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_noteoff_retrigger();
    send(8'h11, 1'b0);
    total++; if (voice_en !== 4'b0001) begin bad++; $display("FAIL on11_en: got %b want 0001", voice_en); end
    total++; if (voice_note[6:0] !== 7'h11) begin bad++; $display("FAIL on11_note: got %h want 11", voice_note[6:0]); end
    send(8'h22, 1'b0);
    total++; if (voice_en !== 4'b0011) begin bad++; $display("FAIL on22_en: got %b want 0011", voice_en); end
    total++; if (voice_note[13:7] !== 7'h22) begin bad++; $display("FAIL on22_note: got %h want 22", voice_note[13:7]); end
    send(8'h91, 1'b0);
    total++; if (voice_en !== 4'b0010) begin bad++; $display("FAIL off11_en: got %b want 0010", voice_en); end
    total++; if (voice_note[6:0] !== 7'h11) begin bad++; $display("FAIL off11_note: got %h want 11", voice_note[6:0]); end
    repeat (100) tick();
    send(8'h22, 1'b0);
    total++; if (voice_en !== 4'b0010) begin bad++; $display("FAIL retrig_en: got %b want 0010", voice_en); end
    repeat (T - 1) tick();
    total++; if (voice_en !== 4'b0010) begin bad++; $display("FAIL retrig_hold: got %b want 0010", voice_en); end
    tick();
    total++; if (voice_en !== 4'b0000) begin bad++; $display("FAIL retrig_expire: got %b want 0000", voice_en); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL retrig_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_steal();
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      send(8'(k), 1'b0);
      repeat (497) tick();
    end
    total++; if (voice_en !== 4'b1111) begin bad++; $display("FAIL full_en: got %b want 1111", voice_en); end
    send(8'h05, 1'b0);
`ifdef VOICE_STEAL_EN
    total++; if (steal !== 1'b1) begin bad++; $display("FAIL steal_pulse: got %b want 1", steal); end
    total++; if (voice_note[6:0] !== 7'h05) begin bad++; $display("FAIL steal_note: got %h want 05", voice_note[6:0]); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL steal_drop: got %0d want 0", drop_cnt); end
`else
    total++; if (steal !== 1'b0) begin bad++; $display("FAIL nosteal_pulse: got %b want 0", steal); end
    total++; if (voice_note !== {7'h04, 7'h03, 7'h02, 7'h01}) begin bad++; $display("FAIL nosteal_notes: got %h want unchanged", voice_note); end
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL nosteal_drop: got %0d want 1", drop_cnt); end
`endif
    total++; if (voice_en !== 4'b1111) begin bad++; $display("FAIL after5_en: got %b want 1111", voice_en); end
    tick();
    total++; if (steal !== 1'b0) begin bad++; $display("FAIL steal_oneshot: got %b want 0", steal); end
  endtask

  task automatic test_errors();
    apply_reset();
    send(8'h10, 1'b1);
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL err_drop: got %0d want 1", drop_cnt); end
    send(8'h00, 1'b0);
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL zero_drop: got %0d want 2", drop_cnt); end
    total++; if (voice_en !== 4'b0000) begin bad++; $display("FAIL err_en: got %b want 0000", voice_en); end
    for (int k = 0; k < 300; k++) begin
      UART_msg = 8'h10; UART_err = 1'b1; UART_valid = 1'b1;
      tick();
      UART_valid = 1'b0; UART_err = 1'b0;
      tick();
      if (k == 249) begin
        total++; if (drop_cnt !== 8'd252) begin bad++; $display("FAIL drop_252: got %0d want 252", drop_cnt); end
      end
    end
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end
    total++; if (voice_en !== 4'b0000) begin bad++; $display("FAIL sat_en: got %b want 0000", voice_en); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    UART_msg = 8'h40; UART_valid = 1'b1;
    tick();
    UART_valid = 1'b0;
    tick();
    UART_msg = 8'h41; UART_valid = 1'b1;
    tick();
    UART_valid = 1'b0;
    total++; if (voice_en !== 4'b0001) begin bad++; $display("FAIL b2b_en: got %b want 0001", voice_en); end
    total++; if (voice_note[6:0] !== 7'h40) begin bad++; $display("FAIL b2b_note: got %h want 40", voice_note[6:0]); end
    repeat (4) tick();
    total++; if (voice_en !== 4'b0001) begin bad++; $display("FAIL b2b_en_late: got %b want 0001", voice_en); end
    total++; if (voice_note[13:7] !== 7'h00) begin bad++; $display("FAIL b2b_v1: got %h want 00", voice_note[13:7]); end
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL b2b_drop: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    total++; if (voice_en !== 4'b0111) begin bad++; $display("FAIL mid_pre_en: got %b want 0111", voice_en); end
    UART_msg = 8'h04; UART_valid = 1'b1;
    tick();
    UART_valid = 1'b0;
    tick();
    #2 rstb = 1'b0;
    #1;
    total++; if (voice_en !== 4'b0000) begin bad++; $display("FAIL mid_rst_en: got %b want 0000", voice_en); end
    total++; if (voice_note !== 28'h0) begin bad++; $display("FAIL mid_rst_note: got %h want 0", voice_note); end
    total++; if (steal !== 1'b0) begin bad++; $display("FAIL mid_rst_steal: got %b want 0", steal); end
    #2 rstb = 1'b1;
    tick();
    send(8'h33, 1'b0);
    total++; if (voice_en !== 4'b0001) begin bad++; $display("FAIL post_rst_en: got %b want 0001", voice_en); end
    total++; if (voice_note !== {21'h0, 7'h33}) begin bad++; $display("FAIL post_rst_note: got %h want 33", voice_note); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL post_rst_drop: got %0d want 0", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_noteoff_retrigger();
    test_steal();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
